// File: rtl/deb_filter_multi.sv
// Multi-channel debounce filter: 2-flop synchroniser, prescaled sampling into a
// WINDOW-deep history, voted registered level with rise/fall pulses.
// Define DEB_FILTER_HYST_EN for hysteresis voting (unanimous window to change).
module deb_filter_multi #(
  parameter int   CHANNELS    = 4,
  parameter int   PRESCALE_W  = 4,
  parameter int   WINDOW      = 5,
  parameter logic RESET_LEVEL = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                sample_tick
);

  localparam int CNT_W = $clog2(WINDOW + 1);

  logic [PRESCALE_W-1:0]              presc_q, presc_d;
  logic [CHANNELS-1:0]                sync1_q, sync2_q;
  logic [CHANNELS-1:0][WINDOW-1:0]    hist_q, hist_d;
  logic [CHANNELS-1:0]                out_q, out_d;
  logic [CHANNELS-1:0]                rise_q, rise_d;
  logic [CHANNELS-1:0]                fall_q, fall_d;
  logic [CHANNELS-1:0][CNT_W-1:0]     cnt;

  assign sample_tick = enable & (presc_q == '1);
  assign out         = out_q;
  assign rise        = rise_q;
  assign fall        = fall_q;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      cnt[c] = '0;
      for (int k = 0; k < WINDOW; k++) begin
        cnt[c] = cnt[c] + CNT_W'(hist_q[c][k]);
      end
    end
  end

  // The vote runs every enabled cycle; since the history only moves on a tick,
  // out settles exactly one clock after each shift and holds in between.
  always_comb begin
    presc_d = presc_q;
    hist_d  = hist_q;
    out_d   = out_q;
    rise_d  = '0;
    fall_d  = '0;
    if (enable) begin
      presc_d = presc_q + PRESCALE_W'(1);
      for (int c = 0; c < CHANNELS; c++) begin
`ifdef DEB_FILTER_HYST_EN
        if (cnt[c] == CNT_W'(WINDOW)) begin
          out_d[c] = 1'b1;
        end else if (cnt[c] == '0) begin
          out_d[c] = 1'b0;
        end
`else
        out_d[c] = (cnt[c] > CNT_W'(WINDOW / 2));
`endif
      end
      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;
    end
    if (sample_tick) begin
      for (int c = 0; c < CHANNELS; c++) begin
        hist_d[c] = {sync2_q[c], hist_q[c][WINDOW-1:1]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      sync1_q <= {CHANNELS{RESET_LEVEL}};
      sync2_q <= {CHANNELS{RESET_LEVEL}};
      hist_q  <= {(CHANNELS * WINDOW){RESET_LEVEL}};
      out_q   <= {CHANNELS{RESET_LEVEL}};
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      presc_q <= presc_d;
      sync1_q <= in;
      sync2_q <= sync1_q;
      hist_q  <= hist_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

endmodule

// File: tb/tb_deb_filter_multi.sv
// Bench for deb_filter_multi: directed scenarios plus random traffic, checked
// against a sample-window reference model (honours DEB_FILTER_HYST_EN).
module tb_deb_filter_multi;

  localparam int   CH = 2;
  localparam int   PW = 2;
  localparam int   W  = 5;
  localparam logic RL = 1'b1;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [CH-1:0] in_r;
  logic [CH-1:0] out_w, rise_w, fall_w;
  logic          tick_w;

  always #5 clock = ~clock;

  deb_filter_multi #(
    .CHANNELS(CH), .PRESCALE_W(PW), .WINDOW(W), .RESET_LEVEL(RL)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .in(in_r),
    .out(out_w), .rise(rise_w), .fall(fall_w), .sample_tick(tick_w)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: input delay line, sample-window arrays, expected outputs.
  int            m_presc;
  logic [CH-1:0] m_s1, m_s2;
  bit            m_win[CH][W];
  logic [CH-1:0] exp_out, exp_rise, exp_fall;

  function automatic int ones(int c);
    int n = 0;
    for (int k = 0; k < W; k++) n += int'(m_win[c][k]);
    return n;
  endfunction

  function automatic logic exp_tick();
    return enable && (m_presc == (1 << PW) - 1);
  endfunction

  task automatic clk_step();
    logic [CH-1:0] nout;
    bit tk;
    int n;
    tk = exp_tick();
    if (reset) begin
      m_presc = 0;
      m_s1 = {CH{RL}};
      m_s2 = {CH{RL}};
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < W; k++) m_win[c][k] = RL;
      exp_out = {CH{RL}};
      exp_rise = '0;
      exp_fall = '0;
    end else begin
      if (enable) begin
        for (int c = 0; c < CH; c++) begin
          n = ones(c);
`ifdef DEB_FILTER_HYST_EN
          nout[c] = (n == W) ? 1'b1 : (n == 0) ? 1'b0 : exp_out[c];
`else
          nout[c] = (n > W / 2);
`endif
        end
        exp_rise = nout & ~exp_out;
        exp_fall = ~nout & exp_out;
        exp_out  = nout;
        m_presc  = (m_presc + 1) % (1 << PW);
      end else begin
        exp_rise = '0;
        exp_fall = '0;
      end
      if (tk) begin
        for (int c = 0; c < CH; c++) begin
          for (int k = W - 1; k > 0; k--) m_win[c][k] = m_win[c][k-1];
          m_win[c][0] = m_s2[c];
        end
      end
      m_s2 = m_s1;
      m_s1 = in_r;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; in_r = 2'b11;
    repeat (3) clk_step();
    vectors++;
    if (out_w !== 2'b11 || rise_w !== 2'b00 || fall_w !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: out=%b rise=%b fall=%b, want 11/00/00", out_w, rise_w, fall_w);
    end
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (tick_w !== 1'((k % 4) == 3)) begin
        errors++;
        $display("FAIL reset_tick cyc %0d: tick=%b want %b", k, tick_w, (k % 4) == 3);
      end
      vectors++;
      if (out_w !== 2'b11 || rise_w !== 2'b00 || fall_w !== 2'b00) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: out=%b rise=%b fall=%b", k, out_w, rise_w, fall_w);
      end
      clk_step();
    end
  endtask

  task automatic test_clean_step();
    int nfall = 0;
    in_r = 2'b10;
    for (int k = 0; k < 40; k++) begin
      clk_step();
      if (fall_w[0] === 1'b1) nfall++;
      vectors++;
      if (out_w !== exp_out || rise_w !== exp_rise || fall_w !== exp_fall || out_w[1] !== 1'b1) begin
        errors++;
        $display("FAIL clean_step cyc %0d: out=%b rise=%b fall=%b want %b/%b/%b", k,
                 out_w, rise_w, fall_w, exp_out, exp_rise, exp_fall);
      end
    end
    vectors++;
    if (out_w !== 2'b10 || nfall != 1) begin
      errors++;
      $display("FAIL clean_step_final: out=%b fall0_pulses=%0d want 10 and 1", out_w, nfall);
    end
  endtask

  task automatic glitch_run(input int low_cycles, input string name);
    int nfall = 0;
    in_r = 2'b00;
    for (int k = 0; k < low_cycles + 30; k++) begin
      if (k == low_cycles) in_r = 2'b10;
      clk_step();
      if (fall_w[1] === 1'b1) nfall++;
      vectors++;
      if (out_w !== exp_out || rise_w !== exp_rise || fall_w !== exp_fall || out_w !== 2'b10) begin
        errors++;
        $display("FAIL %s cyc %0d: out=%b rise=%b fall=%b want 10/%b/%b", name, k,
                 out_w, rise_w, fall_w, exp_rise, exp_fall);
      end
    end
    vectors++;
    if (nfall != 0) begin
      errors++;
      $display("FAIL %s_pulses: fall1 pulses=%0d want 0", name, nfall);
    end
  endtask

  task automatic test_glitch();
    // Eight low cycles through the synchroniser cover exactly two tick samples.
    glitch_run(8, "glitch2");
`ifdef DEB_FILTER_HYST_EN
    glitch_run(16, "glitch4");
`endif
  endtask

  task automatic test_enable_freeze();
    logic [CH-1:0] held_out;
    int held_presc;
    int first_tick = -1;
    repeat (6) clk_step();
    enable = 1'b0;
    held_out = exp_out;
    held_presc = m_presc;
    for (int k = 0; k < 20; k++) begin
      in_r = CH'($urandom_range(0, 3));
      clk_step();
      vectors++;
      if (tick_w !== 1'b0 || out_w !== held_out || rise_w !== 2'b00 || fall_w !== 2'b00) begin
        errors++;
        $display("FAIL freeze cyc %0d: tick=%b out=%b rise=%b fall=%b want 0/%b/00/00",
                 k, tick_w, out_w, rise_w, fall_w, held_out);
      end
    end
    in_r = 2'b10;
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (first_tick < 0 && tick_w === 1'b1) first_tick = k;
      vectors++;
      if (tick_w !== exp_tick() || out_w !== exp_out || rise_w !== exp_rise || fall_w !== exp_fall) begin
        errors++;
        $display("FAIL resume cyc %0d: tick=%b out=%b want %b/%b", k, tick_w, out_w, exp_tick(), exp_out);
      end
      clk_step();
    end
    vectors++;
    if (first_tick != 3 - held_presc) begin
      errors++;
      $display("FAIL resume_tick: first tick at %0d want %0d", first_tick, 3 - held_presc);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    in_r = 2'b00;
    for (int k = 0; k < 60 && !found; k++) begin
      if (m_presc == 2 && ones(1) == W - 2 && m_s1[1] == 1'b0 && m_s2[1] == 1'b0) found = 1;
      else clk_step();
    end
    vectors++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_setup: no pre-flip tick within 60 cycles");
    end
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      vectors++;
      if (out_w !== 2'b11 || rise_w !== 2'b00 || fall_w !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: out=%b rise=%b fall=%b want 11/00/00", k, out_w, rise_w, fall_w);
      end
      clk_step();
    end
    for (int k = 0; k < 30; k++) begin
      vectors++;
      if (out_w !== exp_out || rise_w !== exp_rise || fall_w !== exp_fall) begin
        errors++;
        $display("FAIL reset_refill cyc %0d: out=%b rise=%b fall=%b want %b/%b/%b", k,
                 out_w, rise_w, fall_w, exp_out, exp_rise, exp_fall);
      end
      clk_step();
    end
  endtask

  task automatic test_simultaneous();
    int hit = -1;
    in_r = 2'b10;
    repeat (60) clk_step();
    vectors++;
    if (out_w !== 2'b10) begin
      errors++;
      $display("FAIL simul_setup: out=%b want 10", out_w);
    end
    in_r = 2'b01;
    for (int k = 0; k < 60; k++) begin
      clk_step();
      if (hit < 0 && rise_w[0] === 1'b1) begin
        hit = k;
        vectors++;
        if (fall_w[1] !== 1'b1 || out_w !== 2'b01) begin
          errors++;
          $display("FAIL simul_edge: fall=%b out=%b want fall1=1 out=01", fall_w, out_w);
        end
      end else if (hit >= 0 && k == hit + 1) begin
        vectors++;
        if (rise_w !== 2'b00 || fall_w !== 2'b00) begin
          errors++;
          $display("FAIL simul_width: rise=%b fall=%b want 00/00", rise_w, fall_w);
        end
      end
      vectors++;
      if (out_w !== exp_out || rise_w !== exp_rise || fall_w !== exp_fall) begin
        errors++;
        $display("FAIL simul cyc %0d: out=%b rise=%b fall=%b want %b/%b/%b", k,
                 out_w, rise_w, fall_w, exp_out, exp_rise, exp_fall);
      end
    end
    vectors++;
    if (hit < 0) begin
      errors++;
      $display("FAIL simul_timeout: no rise0 within 60 cycles");
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 7) == 0) in_r[c] = ~in_r[c];
      enable = ($urandom_range(0, 15) != 0);
      reset  = ($urandom_range(0, 249) == 0);
      clk_step();
      vectors++;
      if (out_w !== exp_out || rise_w !== exp_rise || fall_w !== exp_fall || (rise_w & fall_w) !== 2'b00) begin
        errors++;
        $display("FAIL random cyc %0d: out=%b rise=%b fall=%b want %b/%b/%b", k,
                 out_w, rise_w, fall_w, exp_out, exp_rise, exp_fall);
      end
      vectors++;
      if (tick_w !== exp_tick()) begin
        errors++;
        $display("FAIL random_tick cyc %0d: tick=%b want %b", k, tick_w, exp_tick());
      end
    end
    reset = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clean_step();
    test_glitch();
    test_enable_freeze();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/deb_filter_multi.md
Name: deb_filter_multi

Overview:
Multi-channel debounce/glitch filter, the parametrised successor of the single-line 3-sample majority filter. Each channel passes through a 2-flop synchroniser and is sampled on a shared prescaled tick into a WINDOW-deep history. It then drives a majority-voted, registered level with one-cycle rise/fall event pulses. It sits between raw encoder/switch pins and the decode logic.

Parameters:
CHANNELS, 4, number of independent input lines (1..32)
PRESCALE_W, 4, prescaler width; one sample tick every 2^PRESCALE_W enabled clocks (1..16)
WINDOW, 5, samples per vote; odd, 3..15
RESET_LEVEL, 1'b1, value loaded into every history bit and every out bit at reset

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = prescaler runs; 0 = prescaler, histories and outputs freeze
in  input  CHANNELS  raw asynchronous inputs
out  output  CHANNELS  filtered level per channel, registered
rise  output  CHANNELS  one-clock pulse when out[i] goes 0->1
fall  output  CHANNELS  one-clock pulse when out[i] goes 1->0
sample_tick  output  1  high on the cycle a sample is taken (debug/cascade)

Behaviour:
- Reset (sampled on clock edge, reset=1): prescaler=0, sync flops=RESET_LEVEL, every history bit=RESET_LEVEL, out=all RESET_LEVEL, rise=fall=0. Reset mid-window discards the partial history; no rise/fall pulse is generated by reset.
- Synchroniser: 2 flops per channel, always clocked (not gated by enable).
- Prescaler: PRESCALE_W-bit up-counter, +1 per clock while enable=1, wraps 2^PRESCALE_W-1 -> 0.
- sample_tick = enable & (prescaler == all ones); combinational from registered state. First tick after reset occurs in clock cycle 2^PRESCALE_W-1 (cycle 0 = first cycle after reset release).
- On a clock edge with sample_tick=1: hist[i] <= {sync[i], hist[i][WINDOW-1:1]} (newest at MSB, oldest discarded).
- Vote: cnt[i] = popcount(hist[i]), width clog2(WINDOW+1). One clock after each shift edge, out[i] <= (cnt[i] > WINDOW/2) using the updated history. out is held between ticks.
- rise[i]/fall[i] are asserted in the same cycle out[i] changes value and last exactly one clock. rise and fall are never both high for one channel.
- Latency, clean step 0->1 with history all 0: sync 2 clocks, then (WINDOW+1)/2 ticks, then 1 clock to out.
- Glitch rejection: any pulse covering fewer than (WINDOW+1)/2 consecutive-or-not samples within the window never changes out.
- enable=0: prescaler holds its value, no ticks, hist/out hold, rise/fall=0. Re-enable resumes counting from the held value.
- Channels are fully independent; simultaneous transitions on all channels are handled in the same cycle.

Optional Feature:
DEB_FILTER_HYST_EN. When defined: hysteresis voting. out[i] goes 1 only when cnt[i]==WINDOW, goes 0 only when cnt[i]==0, otherwise holds. The step latency becomes WINDOW ticks, and any mixed window leaves out unchanged. When not defined: plain majority vote as above. rise/fall semantics are identical in both builds.

Test Plan:
- Reset: CHANNELS=2, PRESCALE_W=2, WINDOW=5, RESET_LEVEL=1, hold reset 3 clocks -> out=2'b11, rise=fall=0, sample_tick first high 3 clocks after release, then every 4 clocks.
- Clean step: in[0] 1->0 held -> out[0] falls one clock after the 3rd tick that samples 0, fall[0] pulses one clock, out[1] unchanged.
- Glitch: in[1] low for exactly 2 consecutive tick samples, then high -> out[1] stays 1, no fall pulse. With DEB_FILTER_HYST_EN, the same glitch also gives no change and a 4-sample low likewise gives no change.
- Enable freeze: drop enable for 20 clocks mid-window with in toggling -> prescaler, out and history unchanged, no ticks. Re-enable -> ticks resume from the held count.
- Reset mid-operation: assert reset one clock before a tick that would flip out -> out=RESET_LEVEL, no rise/fall pulse, history refilled with RESET_LEVEL.
- Simultaneous: both channels step opposite directions on the same clock -> rise[0] and fall[1] assert in the same cycle, each one clock wide.
